// File: rtl/ifu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ifu_pkg                                                      |
// | Description : Shared types, opcode constants and immediate extractors for  |
// |               the prefetching instruction fetch unit.                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package ifu_pkg;

  localparam int unsigned IFU_XLEN = 32;

  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JAL    = 5'b11011;

  typedef enum logic {
    ST_RUN           = 1'b0,
    ST_REDIRECT_WAIT = 1'b1
  } ifu_state_e;

  typedef struct packed {
    logic [IFU_XLEN-1:0] pc;
    logic [IFU_XLEN-1:0] inst;
    logic                pred_taken;
  } fq_entry_t;

  function automatic logic [IFU_XLEN-1:0] imm_b(input logic [IFU_XLEN-1:0] inst);
    return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

  function automatic logic [IFU_XLEN-1:0] imm_j(input logic [IFU_XLEN-1:0] inst);
    return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ifu_fetch_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ifu_fetch_fifo                                               |
// | Description : Synchronous FIFO of fetched entries with clear; the head is  |
// |               read combinationally from storage.                           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ifu_fetch_fifo
  import ifu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      clear_i,
  input  logic      push_i,
  input  logic      pop_i,
  input  fq_entry_t wdata_i,
  output fq_entry_t head_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int unsigned c_AW = $clog2(DEPTH);

  logic [c_AW:0] wr_ptr_q, wr_ptr_d;
  logic [c_AW:0] rd_ptr_q, rd_ptr_d;
  fq_entry_t     mem_q [DEPTH];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (push_i && !clear_i) mem_q[wr_ptr_q[c_AW-1:0]] <= wdata_i;
    end
  end

  // Extra pointer MSB separates full from empty when the index bits match.
  assign full_o  = (wr_ptr_q[c_AW] != rd_ptr_q[c_AW]) &&
                   (wr_ptr_q[c_AW-1:0] == rd_ptr_q[c_AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign head_o  = mem_q[rd_ptr_q[c_AW-1:0]];

endmodule
`default_nettype wire

// File: rtl/ifu_prefetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ifu_prefetch_queue                                           |
// | Description : Fetch PC owner with redirect handling and a prefetch queue   |
// |               between ICache and decode. Define IFU_BPRED_EN to enable     |
// |               static backward-branch / JAL prediction.                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ifu_prefetch_queue
  import ifu_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     FQ_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic            clock,
  input  logic            reset,
  output logic [XLEN-1:0] cache_addr,
  input  logic            cache_hit,
  input  logic [XLEN-1:0] cache_inst,
  input  logic            jump_flush,
  input  logic [XLEN-1:0] jump_dnpc,
  input  logic            cs_flush,
  input  logic [XLEN-1:0] cs_dnpc,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_inst,
  output logic            out_pred_taken
);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] pend_pc_q, pend_pc_d;
  ifu_state_e      state_q, state_d;

  logic            w_flush;
  logic [XLEN-1:0] w_dnpc;
  logic            w_push;
  logic            w_pop;
  logic            w_full;
  logic            w_empty;
  logic [XLEN-1:0] w_incr;
  logic            w_pred;
  logic [XLEN-1:0] w_next_pc;
  fq_entry_t       w_wdata;
  fq_entry_t       w_head;

  assign w_flush = jump_flush | cs_flush;
  assign w_dnpc  = cs_flush ? cs_dnpc : jump_dnpc;

`ifdef IFU_BPRED_EN
  always_comb begin
    w_incr = XLEN'(4);
    if (cache_inst[6:2] == OP_BRANCH && cache_inst[31]) w_incr = imm_b(cache_inst);
    else if (cache_inst[6:2] == OP_JAL)                 w_incr = imm_j(cache_inst);
  end
  assign w_pred = (w_incr != XLEN'(4));
`else
  assign w_incr = XLEN'(4);
  assign w_pred = 1'b0;
`endif

  assign w_next_pc = fetch_pc_q + w_incr;

  // A flush hides the head in the same cycle so decode never sees a stale entry.
  assign out_valid = ~w_empty & ~w_flush;
  assign w_pop     = out_valid & out_ready;
  assign w_push    = cache_hit & ~w_flush & (state_q == ST_RUN) & (~w_full | w_pop);

  assign w_wdata.pc         = fetch_pc_q;
  assign w_wdata.inst       = cache_inst;
  assign w_wdata.pred_taken = w_pred;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    pend_pc_d  = pend_pc_q;
    state_d    = state_q;
    if (w_flush) begin
      if (cache_hit) begin
        fetch_pc_d = w_dnpc;
        state_d    = ST_RUN;
      end else begin
        // The outstanding miss must return on the old address before redirecting.
        pend_pc_d = w_dnpc;
        state_d   = ST_REDIRECT_WAIT;
      end
    end else if (state_q == ST_REDIRECT_WAIT) begin
      if (cache_hit) begin
        fetch_pc_d = pend_pc_q;
        state_d    = ST_RUN;
      end
    end else if (w_push) begin
      fetch_pc_d = w_next_pc;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      pend_pc_q  <= '0;
      state_q    <= ST_RUN;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      pend_pc_q  <= pend_pc_d;
      state_q    <= state_d;
    end
  end

  ifu_fetch_fifo #(
    .DEPTH (FQ_DEPTH)
  ) u_fifo (
    .clk_i   (clock),
    .rst_i   (reset),
    .clear_i (w_flush),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .wdata_i (w_wdata),
    .head_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  assign cache_addr     = fetch_pc_q;
  assign out_pc         = w_head.pc;
  assign out_inst       = w_head.inst;
  assign out_pred_taken = w_head.pred_taken;

endmodule
`default_nettype wire
